// File: rtl/move_commit_ctrl_if.sv
// Move strobes in, board state and commit/reject pulses out.
interface move_commit_ctrl_if #(
  parameter int unsigned BOARD_N = 3,
  parameter int unsigned IDX_W   = 4
);
  localparam int unsigned NUM_CELLS = BOARD_N * BOARD_N;
  localparam int unsigned CNT_W     = $clog2(NUM_CELLS + 1);

  logic                   clear_board;
  logic [IDX_W-1:0]       human_move_select;
  logic                   human_move_valid;
  logic [IDX_W-1:0]       ai_move_select;
  logic                   ai_move_valid;
  logic [2*NUM_CELLS-1:0] board;
  logic [IDX_W-1:0]       move_out;
  logic                   valid_move;
  logic                   request_new_move_select;
  logic                   turn;
  logic                   board_full;
  logic [CNT_W-1:0]       move_count;

  modport master (
    output clear_board, human_move_select, human_move_valid,
           ai_move_select, ai_move_valid,
    input  board, move_out, valid_move, request_new_move_select,
           turn, board_full, move_count
  );

  modport slave (
    input  clear_board, human_move_select, human_move_valid,
           ai_move_select, ai_move_valid,
    output board, move_out, valid_move, request_new_move_select,
           turn, board_full, move_count
  );
endinterface

// File: rtl/move_commit_ctrl.sv
// Turn-based move validation and board commit for an N x N tic-tac-toe board.
module move_commit_ctrl #(
  parameter int unsigned BOARD_N      = 3,
  parameter int unsigned IDX_W        = 4,
  parameter bit          FIRST_PLAYER = 1'b0
) (
  input logic             clk,
  input logic             reset,
  move_commit_ctrl_if.slave bus
);
  localparam int unsigned NUM_CELLS = BOARD_N * BOARD_N;
  localparam int unsigned CNT_W     = $clog2(NUM_CELLS + 1);
  localparam int unsigned BRD_W     = 2 * NUM_CELLS;

  typedef enum logic [1:0] {
    S_HUMAN = 2'd0,
    S_AI    = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam state_t S_START = FIRST_PLAYER ? S_AI : S_HUMAN;

  state_t           state_q;
  logic [BRD_W-1:0] board_q;
  logic [IDX_W-1:0] move_out_q;
  logic             valid_move_q;
  logic             request_q;
  logic             turn_q;
  logic             board_full_q;
  logic [CNT_W-1:0] move_count_q;

  logic             cand_valid_c;
  logic [IDX_W-1:0] cand_sel_c;
  logic [1:0]       cand_mark_c;
  logic             cell_hit_c;
  logic             cell_free_c;
  logic             legal_c;
  logic [BRD_W-1:0] board_wr_c;
  logic [CNT_W-1:0] count_inc_c;
  logic             last_c;

  // Pick the strobe of whichever player holds the turn; the other is ignored.
  always_comb begin
    cand_valid_c = 1'b0;
    cand_sel_c   = '0;
    cand_mark_c  = 2'b00;
    case (state_q)
      S_HUMAN: begin
        cand_valid_c = bus.human_move_valid;
        cand_sel_c   = bus.human_move_select;
        cand_mark_c  = 2'b01;
      end
      S_AI: begin
        cand_valid_c = bus.ai_move_valid;
        cand_sel_c   = bus.ai_move_select;
        cand_mark_c  = 2'b10;
      end
      default: ;
    endcase
  end

  // Legality: index must hit a real cell and that cell must read 00 (11 counts as occupied).
  always_comb begin
    cell_hit_c  = 1'b0;
    cell_free_c = 1'b0;
    board_wr_c  = board_q;
    for (int unsigned k = 0; k < NUM_CELLS; k++) begin
      if (cand_sel_c == IDX_W'(k)) begin
        cell_hit_c          = 1'b1;
        cell_free_c         = (board_q[2*k +: 2] == 2'b00);
        board_wr_c[2*k +: 2] = cand_mark_c;
      end
    end
    legal_c     = cell_hit_c & cell_free_c;
    count_inc_c = move_count_q + CNT_W'(1);
    last_c      = (count_inc_c == CNT_W'(NUM_CELLS));
  end

  // Turn FSM with registered board, counters and one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_START;
      board_q      <= '0;
      move_out_q   <= '0;
      valid_move_q <= 1'b0;
      request_q    <= 1'b0;
      turn_q       <= FIRST_PLAYER;
      board_full_q <= 1'b0;
      move_count_q <= '0;
    end else begin
      valid_move_q <= 1'b0;
      request_q    <= 1'b0;
      if (bus.clear_board) begin
        state_q      <= S_START;
        board_q      <= '0;
        move_out_q   <= '0;
        turn_q       <= FIRST_PLAYER;
        board_full_q <= 1'b0;
        move_count_q <= '0;
      end else if (cand_valid_c) begin
        if (legal_c) begin
          board_q      <= board_wr_c;
          move_out_q   <= cand_sel_c;
          valid_move_q <= 1'b1;
          move_count_q <= count_inc_c;
          turn_q       <= ~turn_q;
          board_full_q <= last_c;
          if (last_c) state_q <= S_FULL;
          else        state_q <= (state_q == S_HUMAN) ? S_AI : S_HUMAN;
        end else begin
          request_q <= 1'b1;
        end
      end
    end
  end

  assign bus.board                   = board_q;
  assign bus.move_out                = move_out_q;
  assign bus.valid_move              = valid_move_q;
  assign bus.request_new_move_select = request_q;
  assign bus.turn                    = turn_q;
  assign bus.board_full              = board_full_q;
  assign bus.move_count              = move_count_q;
endmodule

// File: doc/move_commit_ctrl.md
# move_commit_ctrl

Registered move-validation and board-commit controller for the tic-tac-toe datapath, and the parametrised successor of the combinational move checker. It generalises the checker to an N×N board and owns the board state itself. Each cycle it accepts a strobed move from whichever player holds the turn, checks it against the stored board, and either commits it or requests a new selection. It sits between the human input / AI move generators and the win-detect and display logic.

## Interface
Parameters:
- BOARD_N, 3: board edge length; legal values 3 or 4; NUM_CELLS = BOARD_N*BOARD_N.
- IDX_W, 4: width of move indices; must satisfy 2^IDX_W >= NUM_CELLS.
- FIRST_PLAYER, 0: turn after reset/clear; 0 = human, 1 = AI.

Ports (CNT_W = $clog2(NUM_CELLS+1)):
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- clear_board  in  1  synchronous new-game request; level-sampled at each edge.
- human_move_select  in  IDX_W  human cell index, row-major, cell 0 = top-left.
- human_move_valid  in  1  one-cycle strobe qualifying human_move_select.
- ai_move_select  in  IDX_W  AI cell index, row-major.
- ai_move_valid  in  1  one-cycle strobe qualifying ai_move_select.
- board  out  2*NUM_CELLS  cell k at bits [2k+1:2k]; 00 empty, 01 human (X), 10 AI (O).
- move_out  out  IDX_W  index of the last committed move.
- valid_move  out  1  one-cycle pulse; a move was committed.
- request_new_move_select  out  1  one-cycle pulse; the current-turn move was rejected.
- turn  out  1  0 = human to move, 1 = AI to move.
- board_full  out  1  high once all NUM_CELLS cells are occupied.
- move_count  out  CNT_W  number of committed moves.

## Operation
- FSM states: S_HUMAN (turn=0), S_AI (turn=1), S_FULL. Reset and clear_board go to S_HUMAN if FIRST_PLAYER=0, else S_AI.
- In S_HUMAN, the controller evaluates only human_move_valid/human_move_select. In S_AI, it evaluates only ai_move_valid/ai_move_select. A strobe from the non-turn player is ignored and produces no pulse.
- A move is legal when index < NUM_CELLS and board cell [index] == 00. A cell value of 11 can never be written and is treated as occupied.
- On a legal move:
  - Write 01 (human) or 10 (AI) into the cell.
  - move_out <= index; valid_move pulses.
  - move_count increments and turn flips.
  - If the new move_count == NUM_CELLS, go to S_FULL instead of the other player's state.
- On an illegal move (occupied or out of range): request_new_move_select pulses. board, move_out, move_count, turn and state are unchanged.
- S_FULL: board_full = 1 and all strobes are ignored. Only clear_board or reset leaves S_FULL.
- clear_board has priority over any strobe in the same cycle:
  - board <= 0, move_count <= 0, move_out <= 0.
  - Both pulses are 0 and board_full is 0; turn and state return to the FIRST_PLAYER value.
- Reset values: board 0, move_out 0, valid_move 0, request_new_move_select 0, turn FIRST_PLAYER, board_full 0, move_count 0.
- move_count never exceeds NUM_CELLS and never wraps.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Latency is 1 cycle: a strobe sampled at edge t is reflected in board/move_out/turn/move_count and in the valid_move or request_new_move_select pulse after edge t. The new values are visible during cycle t+1.
- Pulses last exactly one cycle, and at most one of valid_move / request_new_move_select is high in any cycle.
- A strobe held high for several cycles is evaluated at every edge. After a commit the turn has flipped, so the same player's repeated strobe is ignored.
- The controller accepts back-to-back moves from alternating players on consecutive edges.
- board_full rises in the same cycle as the valid_move pulse of the final commit.
- Asserting reset mid-cycle clears outputs without waiting for clk. Deassertion is synchronised externally.

## Test plan
- BOARD_N=3, human first: human strobes 4, then AI strobes 0 → board bits [9:8]=01 and [1:0]=10, move_count=2, turn=0, two valid_move pulses, no request pulses.
- Human strobes 4 twice across turns (second at AI's cell request) → on AI turn, AI strobes 4: request_new_move_select pulse, board unchanged, turn stays 1.
- Human strobes index 9 on 3×3 and index 15 with human_move_valid=0 → index 9 gives a request pulse with state unchanged; the 15/valid=0 case gives no pulse.
- AI strobes while turn=0, and simultaneous human+AI strobes to cell 2 → AI-only strobe ignored; simultaneous case commits only the human's 01 to cell 2.
- Fill all 9 cells alternately → board_full=1 with the 9th valid_move, move_count=9; a further strobe is ignored; clear_board → board=0, count=0, turn=FIRST_PLAYER.
- BOARD_N=4, IDX_W=4: commit index 15, then assert reset mid-game → board bits [31:30]=01; reset asynchronously zeroes all outputs before the next clk edge.
